// File: rtl/riscv_pkg.sv
// Shared RV32I front-end definitions: redirect encodings, the EBREAK
// encoding and the fetch state constants.
package riscv_pkg;

    // Redirect kinds presented by execute; encoding 3 is reserved and fetched as JAL
    localparam logic [1:0] REDIR_BRANCH = 2'd0;
    localparam logic [1:0] REDIR_JAL    = 2'd1;
    localparam logic [1:0] REDIR_JALR   = 2'd2;

    // The only instruction the front end decodes itself
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    // Fetch state machine
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // True when a fetched word is the EBREAK instruction
    function automatic logic is_ebreak(input logic [31:0] instr);
        return instr == EBREAK_INSTR;
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Redirect target calculation: forms the byte target for BRANCH/JAL/JALR,
// returns the truncated word PC and flags a half-word-aligned target.
module next_pc_calc
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int XLEN   = 32
) (
    input  logic [1:0]        redir_kind,
    input  logic [ADDR_W-1:0] redir_base_pc,
    input  logic [XLEN-1:0]   redir_rs1,
    input  logic [XLEN-1:0]   redir_imm,
    output logic [ADDR_W-1:0] new_pc,
    output logic              misalign
);

    logic [XLEN-1:0] base_byte;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            unused_target_bits;

    // Byte target; PC-relative kinds add to the redirecting instruction's byte address,
    // JALR adds to rs1 and clears bit 0. Reserved kind falls through as JAL.
    always_comb begin
        base_byte                = '0;
        base_byte[ADDR_W+1:0]    = {redir_base_pc, 2'b00};
        jalr_sum                 = redir_rs1 + redir_imm;
        target                   = base_byte + redir_imm;
        case (redir_kind)
            REDIR_JALR:             target = {jalr_sum[XLEN-1:1], 1'b0};
            REDIR_BRANCH, REDIR_JAL: target = base_byte + redir_imm;
            default:                target = base_byte + redir_imm;
        endcase
    end

    // Bits above the instruction-memory range are dropped without complaint;
    // bit 1 is reported but fetch still proceeds from the truncated word address.
    assign new_pc             = target[ADDR_W+1:2];
    assign misalign           = target[1];
    assign unused_target_bits = ^{target[XLEN-1:ADDR_W+2], target[0]};

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, addresses the instruction
// memory, captures the returned word into a valid/ready register for
// decode, applies execute redirects and stops after an EBREAK.
module fetch_pc_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc_current_address,
    input  logic [XLEN-1:0]   Instruction,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [XLEN-1:0]   if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              redir_valid,
    input  logic [1:0]        redir_kind,
    input  logic [ADDR_W-1:0] redir_base_pc,
    input  logic [XLEN-1:0]   redir_rs1,
    input  logic [XLEN-1:0]   redir_imm,
    output logic              redir_misalign,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

    logic [ADDR_W-1:0] pc;
    logic [0:0]        state;
    logic [ADDR_W-1:0] target_pc;
    logic              target_misalign;
    logic              reg_free;
    logic              capture;
    logic              fetch_ebreak;

    next_pc_calc #(
        .ADDR_W (ADDR_W),
        .XLEN   (XLEN)
    ) u_next_pc_calc (
        .redir_kind    (redir_kind),
        .redir_base_pc (redir_base_pc),
        .redir_rs1     (redir_rs1),
        .redir_imm     (redir_imm),
        .new_pc        (target_pc),
        .misalign      (target_misalign)
    );

    assign reg_free     = !if_valid || if_ready;
    assign capture      = !redir_valid && (state == ST_RUN) && reg_free;
    assign fetch_ebreak = is_ebreak(Instruction);

    // PC: redirect target first, otherwise advance after each non-EBREAK capture
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (redir_valid) begin
            pc <= target_pc;
        end else if (capture && !fetch_ebreak) begin
            pc <= pc + PC_STEP;
        end
    end

    // Fetch state: a redirect always resumes RUN since the EBREAK may have been on a wrong path
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else if (redir_valid) begin
            state <= ST_RUN;
        end else if (capture && fetch_ebreak) begin
            state <= ST_HALT;
        end
    end

    // Valid flag: flushed by redirects, set on capture, dropped in HALT once decode takes the EBREAK
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid <= 1'b0;
        end else if (redir_valid) begin
            if_valid <= 1'b0;
        end else if (capture) begin
            if_valid <= 1'b1;
        end else if ((state == ST_HALT) && if_ready) begin
            if_valid <= 1'b0;
        end
    end

    // Fetch register payload: loaded only on capture, otherwise held for decode
    always_ff @(posedge clk) begin
        if (rst) begin
            if_instr <= '0;
            if_pc    <= '0;
        end else if (capture) begin
            if_instr <= Instruction;
            if_pc    <= pc;
        end
    end

    // Misalign flag is a single-cycle pulse following each accepted redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            redir_misalign <= 1'b0;
        end else begin
            redir_misalign <= redir_valid && target_misalign;
        end
    end

    assign pc_current_address = pc;
    assign halted             = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, backpressure,
// redirects of every kind, PC wrap, EBREAK halt/resume and reset priority.
module tb_fetch_pc_unit;

    localparam int ADDR_W = 8;
    localparam int XLEN   = 32;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] pc_current_address;
    logic [XLEN-1:0]   instruction;
    logic              if_valid;
    logic              if_ready;
    logic [XLEN-1:0]   if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              redir_valid;
    logic [1:0]        redir_kind;
    logic [ADDR_W-1:0] redir_base_pc;
    logic [XLEN-1:0]   redir_rs1;
    logic [XLEN-1:0]   redir_imm;
    logic              redir_misalign;
    logic              halted;

    logic [XLEN-1:0]   mem [0:255];
    int                checks;
    int                errors;

    fetch_pc_unit #(
        .ADDR_W (ADDR_W),
        .XLEN   (XLEN)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .pc_current_address (pc_current_address),
        .Instruction        (instruction),
        .if_valid           (if_valid),
        .if_ready           (if_ready),
        .if_instr           (if_instr),
        .if_pc              (if_pc),
        .redir_valid        (redir_valid),
        .redir_kind         (redir_kind),
        .redir_base_pc      (redir_base_pc),
        .redir_rs1          (redir_rs1),
        .redir_imm          (redir_imm),
        .redir_misalign     (redir_misalign),
        .halted             (halted)
    );

    // Combinational instruction memory
    assign instruction = mem[pc_current_address];

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] kind, input logic [7:0] base,
                                  input logic [31:0] rs1, input logic [31:0] imm);
        redir_valid   = 1'b1;
        redir_kind    = kind;
        redir_base_pc = base;
        redir_rs1     = rs1;
        redir_imm     = imm;
    endtask

    // Directed sequence
    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 + (i << 20);
        mem[0] = 32'h0930_0313;
        mem[1] = 32'h0010_0393;

        rst = 1'b1; if_ready = 1'b0; redir_valid = 1'b0; redir_kind = 2'd0;
        redir_base_pc = '0; redir_rs1 = '0; redir_imm = '0;
        tick(); tick();
        check_output("reset_pc", pc_current_address, 32'h0);
        check_output("reset_valid", if_valid, 32'h0);
        check_output("reset_instr", if_instr, 32'h0);
        check_output("reset_ifpc", if_pc, 32'h0);
        check_output("reset_misalign", redir_misalign, 32'h0);
        check_output("reset_halted", halted, 32'h0);

        // Sequential fetch
        rst = 1'b0; if_ready = 1'b1;
        tick();
        check_output("seq0_valid", if_valid, 32'h1);
        check_output("seq0_ifpc", if_pc, 32'h0);
        check_output("seq0_instr", if_instr, 32'h0930_0313);
        check_output("seq0_pc", pc_current_address, 32'h1);
        tick();
        check_output("seq1_ifpc", if_pc, 32'h1);
        check_output("seq1_instr", if_instr, 32'h0010_0393);
        check_output("seq1_pc", pc_current_address, 32'h2);
        tick();
        check_output("seq2_ifpc", if_pc, 32'h2);
        check_output("seq2_pc", pc_current_address, 32'h3);

        // Backpressure for three cycles
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("bp_pc", pc_current_address, 32'h3);
            check_output("bp_ifpc", if_pc, 32'h2);
            check_output("bp_instr", if_instr, 32'h0020_0013);
            check_output("bp_valid", if_valid, 32'h1);
        end
        if_ready = 1'b1;
        tick();
        check_output("resume_ifpc", if_pc, 32'h3);
        check_output("resume_pc", pc_current_address, 32'h4);

        // BRANCH base 5 imm -8 -> byte 12 -> word 3
        apply_stimulus(2'd0, 8'd5, 32'h0, 32'hFFFF_FFF8);
        tick();
        check_output("br_pc", pc_current_address, 32'h3);
        check_output("br_bubble", if_valid, 32'h0);
        check_output("br_misalign", redir_misalign, 32'h0);
        redir_valid = 1'b0;
        tick();
        check_output("br_cap_valid", if_valid, 32'h1);
        check_output("br_cap_ifpc", if_pc, 32'h3);

        // BRANCH base 5 imm 6 -> byte 26 -> word 6, misaligned
        apply_stimulus(2'd0, 8'd5, 32'h0, 32'h6);
        tick();
        check_output("mis_pc", pc_current_address, 32'h6);
        check_output("mis_pulse", redir_misalign, 32'h1);
        redir_valid = 1'b0;
        tick();
        check_output("mis_clear", redir_misalign, 32'h0);
        check_output("mis_cap_ifpc", if_pc, 32'h6);
        check_output("mis_cap_instr", if_instr, 32'h0060_0013);

        // JALR rs1 0x401 imm 4 -> byte 0x404 -> word 1
        apply_stimulus(2'd2, 8'd0, 32'h0000_0401, 32'h4);
        tick();
        check_output("jalr_pc", pc_current_address, 32'h1);
        check_output("jalr_misalign", redir_misalign, 32'h0);

        // JAL to byte 0x3FC -> word 255, then wrap
        apply_stimulus(2'd1, 8'd0, 32'h0, 32'd1020);
        tick();
        check_output("wrap_pc255", pc_current_address, 32'hFF);
        redir_valid = 1'b0;
        tick();
        check_output("wrap_ifpc", if_pc, 32'hFF);
        check_output("wrap_instr", if_instr, 32'h0FF0_0013);
        check_output("wrap_pc0", pc_current_address, 32'h0);
        tick();
        check_output("wrap_ifpc0", if_pc, 32'h0);

        // EBREAK at address 4
        mem[4] = 32'h0010_0073;
        apply_stimulus(2'd1, 8'd4, 32'h0, 32'h0);
        tick();
        check_output("eb_redir_pc", pc_current_address, 32'h4);
        redir_valid = 1'b0;
        if_ready = 1'b0;
        tick();
        check_output("eb_valid", if_valid, 32'h1);
        check_output("eb_ifpc", if_pc, 32'h4);
        check_output("eb_instr", if_instr, 32'h0010_0073);
        check_output("eb_halted", halted, 32'h1);
        check_output("eb_pc", pc_current_address, 32'h4);
        tick();
        check_output("eb_hold_valid", if_valid, 32'h1);
        check_output("eb_hold_pc", pc_current_address, 32'h4);
        if_ready = 1'b1;
        tick();
        check_output("eb_accept_valid", if_valid, 32'h0);
        check_output("eb_accept_halted", halted, 32'h1);
        tick();
        check_output("eb_idle_valid", if_valid, 32'h0);
        check_output("eb_idle_pc", pc_current_address, 32'h4);

        // JAL base 4 imm 8 -> word 6 resumes fetch
        apply_stimulus(2'd1, 8'd4, 32'h0, 32'h8);
        tick();
        check_output("res_halted", halted, 32'h0);
        check_output("res_pc", pc_current_address, 32'h6);
        redir_valid = 1'b0;
        tick();
        check_output("res_valid", if_valid, 32'h1);
        check_output("res_ifpc", if_pc, 32'h6);

        // Reset beats a simultaneous misaligned redirect
        apply_stimulus(2'd0, 8'd5, 32'h0, 32'h6);
        rst = 1'b1;
        tick();
        check_output("rst_pc", pc_current_address, 32'h0);
        check_output("rst_valid", if_valid, 32'h0);
        check_output("rst_halted", halted, 32'h0);
        check_output("rst_misalign", redir_misalign, 32'h0);
        rst = 1'b0;
        redir_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end of the RV32I core, directly upstream of the instruction memory. It owns the program counter and drives the memory's 8-bit word address every cycle. It captures the returned 32-bit instruction into a valid/ready fetch register for decode. It applies branch, JAL and JALR redirects from execute and stops fetching after an EBREAK.

## Interface
Parameters:
- ADDR_W, 8, word-address width; must equal the instruction-memory address width.
- XLEN, 32, data and instruction width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- pc_current_address  out  ADDR_W  word address to the instruction memory; driven straight from the PC register.
- Instruction  in  XLEN  memory read data; combinational from pc_current_address in the same cycle.
- if_valid  out  1  fetch register holds an instruction.
- if_ready  in  1  decode accepts the fetch register this cycle.
- if_instr  out  XLEN  fetched instruction.
- if_pc  out  ADDR_W  word address of if_instr.
- redir_valid  in  1  execute requests a redirect.
- redir_kind  in  2  redirect type: 0 = BRANCH, 1 = JAL, 2 = JALR, 3 = reserved.
- redir_base_pc  in  ADDR_W  word address of the redirecting instruction.
- redir_rs1  in  XLEN  JALR base register value.
- redir_imm  in  XLEN  sign-extended byte immediate.
- redir_misalign  out  1  one-cycle pulse: accepted redirect target had byte-address bit 1 set.
- halted  out  1  fetch stopped on EBREAK.

## Operation
Reset values (rst = 1 at an edge):
- PC = 0; if_valid = 0; if_instr = 0; if_pc = 0.
- redir_misalign = 0; halted = 0; state = RUN.
- rst overrides every other input, including a redirect in the same cycle.

States:
- RUN: fetching.
- HALT: stopped after capturing an EBREAK.

Fetch register is free when if_valid = 0 or if_ready = 1.

Priority each edge, highest first:
1. redir_valid:
   - PC ← target; if_valid ← 0 (flush); state ← RUN; halted ← 0.
   - redir_misalign ← target bit 1.
   - Applies in any state, including HALT, because the EBREAK may have been on a wrong path.
2. RUN and fetch register free:
   - if_instr ← Instruction; if_pc ← PC; if_valid ← 1.
   - If Instruction = 32'h00100073 (EBREAK): PC holds; state ← HALT; halted ← 1.
   - Otherwise PC ← PC + 1, modulo 2^ADDR_W (255 wraps to 0).
3. RUN and fetch register not free (if_valid = 1, if_ready = 0): PC and fetch register hold; the address is re-presented unchanged.
4. HALT: no capture. if_valid ← 0 once accepted (if_ready = 1); PC holds.

Target computation (byte address T, XLEN bits, wrap-around modulo 2^XLEN):
- BRANCH / JAL: T = {redir_base_pc, 2'b00} + redir_imm.
- JALR: T = (redir_rs1 + redir_imm) & ~1.
- New PC = T[ADDR_W+1:2]. Upper bits are discarded silently.
- T[1] sets redir_misalign; fetch still proceeds from the truncated word address.
- redir_kind = 3 is treated as JAL.

## Timing
- pc_current_address is registered: it changes only at clock edges.
- Memory read is the only combinational path: Instruction → if_instr D-input.
- Capture latency: an instruction at address A appears on if_instr one edge after PC = A with the register free.
- Back-to-back throughput: one instruction per cycle while if_ready = 1.
- Redirect asserted in cycle N:
  - PC = target from edge N+1.
  - if_valid = 0 during cycle N+1.
  - Target instruction valid from edge N+2 (one bubble).
- Redirect and if_ready = 1 in the same cycle: the flush wins; the old if_instr counts as accepted by decode but is discarded.
- redir_misalign is high exactly for the cycle after the redirect edge.

## Structure
- Shared package riscv_pkg holds:
  - REDIR_BRANCH / REDIR_JAL / REDIR_JALR encodings.
  - EBREAK_INSTR = 32'h00100073.
  - The state enumeration (RUN, HALT).
- One combinational sub-module, next_pc_calc: inputs redir_kind, redir_base_pc, redir_rs1, redir_imm; outputs new word PC and the misalign bit.
- PC register, fetch register and state machine stay in fetch_pc_unit.

## Test plan
1. Reset, then the memory model returns 32'h09300313 at address 0, 32'h00100393 at address 1, with if_ready = 1:
   - Address sequence 0, 1, 2, …
   - if_valid first high one edge after reset release.
   - if_pc = 0, 1 on consecutive cycles; if_instr matches.
2. Backpressure: hold if_ready = 0 for 3 cycles after if_pc = 2 is captured:
   - pc_current_address stays 3.
   - if_instr and if_pc hold.
   - Flow resumes with if_pc = 3 on the first edge where if_ready = 1.
3. Redirect BRANCH with base_pc = 5, imm = −8:
   - PC = 3 next cycle; one bubble (if_valid = 0); then if_pc = 3.
   - BRANCH with imm = 6: PC = 6, redir_misalign pulses for one cycle.
4. JALR with rs1 = 32'h0000_0401, imm = 4:
   - T = 0x404, PC = 8'h01 (bit 10 discarded).
   - Wrap check: PC = 255 sequential fetch → next address 0.
5. EBREAK at address 4:
   - Captured with if_pc = 4; halted = 1; PC stays 4.
   - No further captures; if_valid drops after acceptance.
   - A JAL redirect then clears halted and fetch resumes at the target.
6. Assert rst mid-stream with if_valid = 1 and redir_valid = 1 in the same cycle:
   - Next cycle PC = 0, if_valid = 0, halted = 0, redir_misalign = 0.
